// File: rtl/j2fam_bus_pkg.sv
// j2fam_bus_pkg: address-map decode and responder state types shared by the memory responder.
package j2fam_bus_pkg;
    typedef enum logic [1:0] {REGION_RAM, REGION_ROM, REGION_UNMAPPED} region_e;
    typedef enum logic [2:0] {IDLE, RAM_WAIT, ROM_WAIT, DONE, ABORT} responder_state_e;

    localparam logic [15:0] RAM_MIRROR_END = 16'h1FFF;
    localparam logic [15:0] ROM_BASE       = 16'h8000;

    function automatic region_e decode_region(input logic [15:0] address);
        return address <= RAM_MIRROR_END ? REGION_RAM :
               address >= ROM_BASE       ? REGION_ROM : REGION_UNMAPPED;
    endfunction
endpackage

// File: rtl/memory_responder_if.sv
// memory_responder_if: level-held CPU request and held response between CPU and responder.
interface memory_responder_if;
    logic [15:0] req_address;
    logic        req_address_valid;
    logic        req_write;
    logic [7:0]  req_data;
    logic [7:0]  resp_data;
    logic        resp_data_valid;

    modport master (
        output req_address, req_address_valid, req_write, req_data,
        input  resp_data, resp_data_valid
    );
    modport slave (
        input  req_address, req_address_valid, req_write, req_data,
        output resp_data, resp_data_valid
    );
endinterface

// File: rtl/work_ram.sv
// work_ram: single-port byte RAM with registered read; a write leaves the read port unchanged.
module work_ram #(
    parameter int ADDRESS_BITS = 11
) (
    input  logic                    clock_i,
    input  logic                    write_i,
    input  logic [ADDRESS_BITS-1:0] address_i,
    input  logic [7:0]              data_i,
    output logic [7:0]              data_o
);
    logic [7:0] mem [2**ADDRESS_BITS];

    always_ff @(posedge clock_i) begin
        if (write_i)
            mem[address_i] <= data_i;
        else
            data_o <= mem[address_i];
    end
endmodule

// File: rtl/memory_responder.sv
// memory_responder: decodes CPU requests onto mirrored work RAM, external ROM or open bus,
// and holds each response until the CPU presents a different request.
module memory_responder
    import j2fam_bus_pkg::*;
#(
    parameter int RAM_ADDRESS_BITS   = 11,
    parameter int ROM_TIMEOUT_CYCLES = 255
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    memory_responder_if.slave bus,
    output logic [14:0]       rom_address_o,
    output logic              rom_read_o,
    input  logic [7:0]        rom_data_i,
    input  logic              rom_data_valid_i,
    output logic              rom_timeout_o
);
    localparam logic [7:0] TIMEOUT_LAST = 8'(ROM_TIMEOUT_CYCLES - 1);

    responder_state_e state_q, state_d;
    logic [15:0] lat_address_q;
    logic [7:0]  lat_data_q, cnt_q, cnt_d, resp_data_q, resp_data_d, ram_data;
    logic        lat_write_q, seen_q, pend_q, pend_d;
    logic        resp_valid_q, resp_valid_d, rom_read_d, rom_timeout_d;
    logic        new_req, accept, ram_write;
    region_e     region;

    assign region  = decode_region(bus.req_address);
    assign new_req = bus.req_address_valid && (!seen_q ||
                     {bus.req_address, bus.req_write, bus.req_data} != {lat_address_q, lat_write_q, lat_data_q});
    // RAM is always addressed by the latched request, so it is touched the cycle after acceptance
    assign ram_write = pend_q && lat_write_q && decode_region(lat_address_q) == REGION_RAM;
    assign bus.resp_data       = resp_data_q;
    assign bus.resp_data_valid = resp_valid_q;

    work_ram #(.ADDRESS_BITS(RAM_ADDRESS_BITS)) u_work_ram (
        .clock_i  (clock_i),
        .write_i  (ram_write),
        .address_i(lat_address_q[RAM_ADDRESS_BITS-1:0]),
        .data_i   (lat_data_q),
        .data_o   (ram_data)
    );

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        resp_data_d   = resp_data_q;
        resp_valid_d  = resp_valid_q;
        rom_read_d    = rom_read_o;
        rom_timeout_d = 1'b0;
        cnt_d         = cnt_q + 8'd1;
        pend_d        = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                accept = new_req;
                if (pend_q) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = lat_write_q ? lat_data_q : resp_data_q;
                end
            end
            RAM_WAIT: begin
                if (new_req) begin
                    state_d = ABORT;
                end else if (cnt_q == 8'd1) begin
                    state_d      = DONE;
                    resp_data_d  = ram_data;
                    resp_valid_d = 1'b1;
                end
            end
            ROM_WAIT: begin
                if (new_req) begin
                    state_d    = ABORT;
                    rom_read_d = 1'b0;
                end else if (rom_data_valid_i) begin
                    state_d      = DONE;
                    resp_data_d  = rom_data_i;
                    resp_valid_d = 1'b1;
                    rom_read_d   = 1'b0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = DONE;
                    resp_valid_d  = 1'b1;
                    rom_read_d    = 1'b0;
                    rom_timeout_d = 1'b1;
                end
            end
            ABORT: begin
                // the aborting tuple was never latched, so take whatever is on the bus now
                accept  = bus.req_address_valid;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            resp_valid_d = 1'b0;
            cnt_d        = '0;
            pend_d       = bus.req_write || region == REGION_UNMAPPED;
            rom_read_d   = !bus.req_write && region == REGION_ROM;
            state_d      = pend_d ? DONE : rom_read_d ? ROM_WAIT : RAM_WAIT;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= IDLE;
            lat_address_q <= '0;
            lat_write_q   <= 1'b0;
            lat_data_q    <= '0;
            seen_q        <= 1'b0;
            pend_q        <= 1'b0;
            cnt_q         <= '0;
            resp_data_q   <= '0;
            resp_valid_q  <= 1'b0;
            rom_address_o <= '0;
            rom_read_o    <= 1'b0;
            rom_timeout_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            cnt_q         <= cnt_d;
            resp_data_q   <= resp_data_d;
            resp_valid_q  <= resp_valid_d;
            rom_read_o    <= rom_read_d;
            rom_timeout_o <= rom_timeout_d;
            if (accept) begin
                lat_address_q <= bus.req_address;
                lat_write_q   <= bus.req_write;
                lat_data_q    <= bus.req_data;
                seen_q        <= 1'b1;
                rom_address_o <= bus.req_address[14:0];
            end
        end
    end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: randomized and directed requests against a byte-array/open-bus model,
// with responses checked by a monitor that pops an expected-response queue.
module tb_memory_responder;
    localparam int TMO = 4;

    typedef struct {
        int data;
        int cycle;
        int timeout;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [14:0] rom_address;
    logic        rom_read;
    logic [7:0]  rom_data = 8'h00;
    logic        rom_dv = 1'b0;
    logic        rom_timeout;
    int          cycle = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];
    logic [7:0]  ram_m [2048];
    logic [7:0]  open_bus = 8'h00;
    logic [24:0] last = '0;

    memory_responder_if bus();

    memory_responder #(.RAM_ADDRESS_BITS(11), .ROM_TIMEOUT_CYCLES(TMO)) dut (
        .clock_i         (clock),
        .reset_ni        (reset_n),
        .bus             (bus),
        .rom_address_o   (rom_address),
        .rom_read_o      (rom_read),
        .rom_data_i      (rom_data),
        .rom_data_valid_i(rom_dv),
        .rom_timeout_o   (rom_timeout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    task automatic await_resp(input int lat);
        repeat (lat + 2) @(posedge clock);
        @(negedge clock);
        #1;
        check("resp_seen", exp_q.size(), 0);
        check("timeout_pulse_end", rom_timeout, 0);
        exp_q.delete();
    endtask

    // Model: RAM reads answer 2 edges after the request, ROM reads when the ROM answers
    // (or open bus at the timeout), everything else 1 edge later; writes echo their data.
    task automatic issue(input logic [15:0] a, input logic w, input logic [7:0] d, input int rd, input logic [7:0] rb);
        exp_t e;
        int   lat;
        logic is_ram, rom_rd;
        is_ram    = a < 16'h2000;
        rom_rd    = !w && a >= 16'h8000;
        lat       = 1;
        e.data    = w ? d : open_bus;
        e.timeout = 0;
        if (is_ram && w) ram_m[a[10:0]] = d;
        if (is_ram && !w) begin
            lat    = 2;
            e.data = ram_m[a[10:0]];
        end
        if (rom_rd) begin
            lat       = rd > 0 ? rd : TMO;
            e.data    = rd > 0 ? rb : open_bus;
            e.timeout = int'(rd == 0);
        end
        open_bus = 8'(e.data);
        @(negedge clock);
        bus.req_address       = a;
        bus.req_write         = w;
        bus.req_data          = d;
        bus.req_address_valid = 1'b1;
        last    = {a, w, d};
        e.cycle = cycle + 1 + lat;
        exp_q.push_back(e);
        @(negedge clock);
        check("valid_drop", bus.resp_data_valid, 0);
        check("rom_read", rom_read, rom_rd);
        if (rom_rd) check("rom_address", rom_address, a[14:0]);
        if (rom_rd && rd > 0) begin
            repeat (rd - 1) @(negedge clock);
            rom_dv   = 1'b1;
            rom_data = rb;
            @(negedge clock);
            rom_dv = 1'b0;
        end
        await_resp(lat);
    endtask

    initial begin : monitor
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.resp_data_valid && !prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", bus.resp_data, e.data);
                    check("resp_cycle", cycle, e.cycle);
                    check("resp_timeout", rom_timeout, e.timeout);
                    check("resp_rom_read", rom_read, 0);
                end
            end
            prev = bus.resp_data_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [15:0] a;
        logic        w;
        logic [7:0]  d;
        int          k;
        bus.req_address = '0;
        bus.req_address_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_data = '0;
        repeat (3) @(negedge clock);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_resp_valid", bus.resp_data_valid, 0);
        check("rst_rom_address", rom_address, 0);
        check("rst_rom_read", rom_read, 0);
        check("rst_rom_timeout", rom_timeout, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_no_resp", bus.resp_data_valid, 0);

        issue(16'hFFFC, 1'b0, 8'h00, 3, 8'h34);
        issue(16'hFFFD, 1'b0, 8'h00, 1, 8'($urandom));
        issue(16'h0005, 1'b1, 8'h42, 0, 8'h00);
        issue(16'h0805, 1'b0, 8'h00, 0, 8'h00);
        issue(16'h1805, 1'b0, 8'h00, 0, 8'h00);

        bus.req_address_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("hold_valid", bus.resp_data_valid, 1);
        check("hold_data", bus.resp_data, open_bus);
        bus.req_address_valid = 1'b1;
        repeat (3) @(negedge clock);
        check("same_tuple_valid", bus.resp_data_valid, 1);

        issue(16'h4000, 1'b0, 8'h00, 0, 8'h00);
        issue(16'h9000, 1'b1, 8'h77, 0, 8'h00);
        issue(16'h8123, 1'b0, 8'h00, 0, 8'h00);

        begin : abort_case
            exp_t e;
            @(negedge clock);
            bus.req_address = 16'h8000;
            bus.req_write = 1'b0;
            bus.req_data = 8'h00;
            repeat (2) @(negedge clock);
            bus.req_address = 16'h0005;
            last = {16'h0005, 1'b0, 8'h00};
            @(negedge clock);
            check("abort_rom_read", rom_read, 0);
            rom_dv = 1'b1;
            rom_data = 8'hEE;
            e.data = ram_m[5];
            e.cycle = cycle + 3;
            e.timeout = 0;
            exp_q.push_back(e);
            open_bus = ram_m[5];
            @(negedge clock);
            rom_dv = 1'b0;
            await_resp(3);
        end

        for (int i = 0; i < 16; i++)
            issue(16'(i | ($urandom_range(0, 3) << 11)), 1'b1, 8'($urandom), 0, 8'h00);

        for (int n = 0; n < 150; n++) begin
            do begin
                k = $urandom_range(0, 2);
                a = k == 0 ? 16'($urandom_range(0, 15) | ($urandom_range(0, 3) << 11)) :
                    k == 1 ? 16'($urandom_range(16'h8000, 16'hFFFF)) : 16'($urandom_range(16'h2000, 16'h7FFF));
                w = 1'($urandom_range(0, 1));
                d = 8'($urandom);
            end while ({a, w, d} == last);
            if ($urandom_range(0, 3) == 0) begin
                bus.req_address_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clock);
                check("idle_hold", bus.resp_data_valid, 1);
            end
            issue(a, w, d, $urandom_range(0, 3), 8'($urandom));
        end

        @(negedge clock);
        bus.req_address = 16'hC000;
        bus.req_write = 1'b0;
        bus.req_data = 8'h00;
        @(negedge clock);
        check("pre_reset_rom_read", rom_read, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rom_read", rom_read, 0);
        check("async_resp_valid", bus.resp_data_valid, 0);
        check("async_resp_data", bus.resp_data, 0);
        bus.req_address_valid = 1'b0;
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        open_bus = 8'h00;
        issue(16'hFFFE, 1'b0, 8'h00, 2, 8'hA5);
        issue(16'h4000, 1'b0, 8'h01, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
